// File: rtl/pal2sel.sv
// pal2sel: slow-to-fast CDC parallel-to-serial transmitter.
// A byte written in the clkb domain is handed to the clka domain with a
// toggle req/ack handshake and shifted out MSB-first while wra_n is low.
// hold_q is read across the crossing without synchronization: it only
// changes on accept, and accept is blocked until the ack has returned.
module pal2sel #(
    parameter int DW   = 8,
    parameter int SYNC = 2
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          clkb,
    input  logic          wrb,
    input  logic [DW-1:0] db_in,
    output logic          busy,
    output logic          drop,
    output logic          wra_n,
    output logic          dout,
    output logic          tx_done
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // clkb domain state
    logic [DW-1:0]   hold_q,     hold_d;
    logic            req_tgl_q,  req_tgl_d;
    logic            drop_q,     drop_d;
    logic [SYNC-1:0] ack_sync_q, ack_sync_d;
    logic            ack_sync;

    // clka domain state
    logic [SYNC-1:0] req_sync_q, req_sync_d;
    logic            req_d_q,    req_d_d;
    logic            req_s;
    logic            req_pulse;
    state_t          state_q,    state_d;
    logic [DW-1:0]   shift_q,    shift_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic            dout_q,     dout_d;
    logic            wra_n_q,    wra_n_d;
    logic            tx_done_q,  tx_done_d;
    logic            ack_tgl_q,  ack_tgl_d;

    // busy is a pure function of two flops, so it is glitch-free in clkb
    assign ack_sync  = ack_sync_q[SYNC-1];
    assign busy      = req_tgl_q ^ ack_sync;
    assign drop      = drop_q;

    assign req_s     = req_sync_q[SYNC-1];
    assign req_pulse = req_s ^ req_d_q;

    assign wra_n     = wra_n_q;
    assign dout      = dout_q;
    assign tx_done   = tx_done_q;

    // clkb side: accept a byte when idle, flag an overrun when busy
    always_comb begin
        hold_d     = hold_q;
        req_tgl_d  = req_tgl_q;
        drop_d     = 1'b0;
        ack_sync_d = {ack_sync_q[SYNC-2:0], ack_tgl_q};
        if (wrb) begin
            if (busy) begin
                drop_d = 1'b1;
            end else begin
                hold_d    = db_in;
                req_tgl_d = ~req_tgl_q;
            end
        end
    end

    // clkb side registers including the ack synchronizer
    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            req_tgl_q  <= 1'b0;
            drop_q     <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            hold_q     <= hold_d;
            req_tgl_q  <= req_tgl_d;
            drop_q     <= drop_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    // clka side next state: the MSB goes out on the load edge, so shift_q
    // holds only the bits still waiting to go on the line
    always_comb begin
        req_sync_d = {req_sync_q[SYNC-2:0], req_tgl_q};
        req_d_d    = req_s;
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        wra_n_d    = wra_n_q;
        tx_done_d  = 1'b0;
        ack_tgl_d  = ack_tgl_q;
        case (state_q)
            IDLE: begin
                if (req_pulse) begin
                    shift_d = {hold_q[DW-2:0], 1'b0};
                    cnt_d   = '0;
                    dout_d  = hold_q[DW-1];
                    wra_n_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(DW - 1)) begin
                    wra_n_d   = 1'b1;
                    dout_d    = 1'b0;
                    tx_done_d = 1'b1;
                    ack_tgl_d = ~ack_tgl_q;
                    state_d   = IDLE;
                end else begin
                    dout_d  = shift_q[DW-1];
                    shift_d = {shift_q[DW-2:0], 1'b0};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clka side FSM, request synchronizer and registered serial outputs
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q <= '0;
            req_d_q    <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            dout_q     <= 1'b0;
            wra_n_q    <= 1'b1;
            tx_done_q  <= 1'b0;
            ack_tgl_q  <= 1'b0;
        end else begin
            req_sync_q <= req_sync_d;
            req_d_q    <= req_d_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            wra_n_q    <= wra_n_d;
            tx_done_q  <= tx_done_d;
            ack_tgl_q  <= ack_tgl_d;
        end
    end

endmodule
